// File: rtl/serial_word_compare.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_compare
// Description : Serial word comparator. Accumulates per-bit XNOR results of
//               two bit-streams over WIDTH accepted bits and reports
//               registered eq/gt/lt with a one-cycle done pulse.
//               Optional define MISMATCH_INDEX_EN adds mis_valid/mis_idx.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_compare #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   bit_valid,
    input  logic                   x,
    input  logic                   y,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic                   eq,
    output logic                   gt,
    output logic                   lt
`ifdef MISMATCH_INDEX_EN
    ,
    output logic                   mis_valid,
    output logic [$clog2(WIDTH):0] mis_idx
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] c_last_idx = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_acc_eq;
    logic          r_acc_gt;
    logic          r_acc_lt;
    logic          r_eq;
    logic          r_gt;
    logic          r_lt;

    logic          w_bit_eq;
    logic          w_take;
    logic          w_restart;
    logic          w_last;
    logic          w_acc_eq_nxt;
    logic          w_acc_gt_nxt;
    logic          w_acc_lt_nxt;

    always_comb begin
        w_bit_eq     = ~(x ^ y);
        w_take       = (r_state == ST_SHIFT) && bit_valid && !start;
        w_restart    = start && (r_state != ST_DONE);
        w_last       = w_take && (r_cnt == c_last_idx);
        w_acc_eq_nxt = r_acc_eq & w_bit_eq;
        w_acc_gt_nxt = r_acc_gt;
        w_acc_lt_nxt = r_acc_lt;
        // MSB-first: first mismatch is most significant; LSB-first: last one is.
        if (!w_bit_eq && ((MSB_FIRST == 0) || r_acc_eq)) begin
            w_acc_gt_nxt = x & ~y;
            w_acc_lt_nxt = ~x & y;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc_eq <= 1'b0;
            r_acc_gt <= 1'b0;
            r_acc_lt <= 1'b0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_lt     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_restart) begin
                r_acc_eq <= 1'b1;
                r_acc_gt <= 1'b0;
                r_acc_lt <= 1'b0;
                r_cnt    <= '0;
            end else if (w_take) begin
                r_acc_eq <= w_acc_eq_nxt;
                r_acc_gt <= w_acc_gt_nxt;
                r_acc_lt <= w_acc_lt_nxt;
                r_cnt    <= r_cnt + CW'(1);
            end
            // Results land with the last bit so they are valid while done is high.
            if (w_last) begin
                r_eq <= w_acc_eq_nxt;
                r_gt <= w_acc_gt_nxt;
                r_lt <= w_acc_lt_nxt;
            end
        end
    end

    assign ready = (r_state == ST_IDLE);
    assign busy  = (r_state == ST_SHIFT);
    assign done  = (r_state == ST_DONE);
    assign eq    = r_eq;
    assign gt    = r_gt;
    assign lt    = r_lt;

`ifdef MISMATCH_INDEX_EN
    logic          r_mis_found;
    logic [CW-1:0] r_mis_pos;
    logic          r_mis_valid;
    logic [CW-1:0] r_mis_idx;
    logic          w_mis_hit;

    assign w_mis_hit = w_take && !w_bit_eq && !r_mis_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mis_found <= 1'b0;
            r_mis_pos   <= '0;
            r_mis_valid <= 1'b0;
            r_mis_idx   <= '0;
        end else begin
            if (w_restart) begin
                r_mis_found <= 1'b0;
                r_mis_pos   <= '0;
            end else if (w_mis_hit) begin
                r_mis_found <= 1'b1;
                r_mis_pos   <= r_cnt;
            end
            if (w_last) begin
                r_mis_valid <= r_mis_found | w_mis_hit;
                r_mis_idx   <= r_mis_found ? r_mis_pos : (w_mis_hit ? r_cnt : '0);
            end
        end
    end

    assign mis_valid = r_mis_valid;
    assign mis_idx   = r_mis_idx;
`endif

endmodule
`default_nettype wire
